// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the front-end pipeline registers: bubble
// instruction, control/register bundle layouts and ResultSrc encodings.
package pipe_stage_regs_pkg;

   // addi x0, x0, 0 : canonical bubble instruction in decode
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Control bundle {RegWrite,ResultSrc[1:0],MemWrite,Jump,Branch,ALUControl[2:0],ALUSrc}
   localparam int CTRL_W            = 10;
   localparam int CTRL_REGWRITE_BIT = 9;
   localparam int CTRL_RESSRC_LSB   = 7;
   localparam int CTRL_MEMWRITE_BIT = 6;
   localparam int CTRL_JUMP_BIT     = 5;
   localparam int CTRL_BRANCH_BIT   = 4;
   localparam int CTRL_ALUCTL_LSB   = 1;
   localparam int CTRL_ALUSRC_BIT   = 0;

   // Register-index bundle {Rs1,Rs2,Rd}
   localparam int REGS_W       = 15;
   localparam int REGS_RD_LSB  = 0;
   localparam int REGS_RS2_LSB = 5;
   localparam int REGS_RS1_LSB = 10;

   // Writeback result source selection
   typedef enum logic [1:0] {
      RS_ALU  = 2'b00,
      RS_LOAD = 2'b01,
      RS_PC4  = 2'b10
   } resultsrc_e;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset to RST_VAL,
// synchronous clear to CLR_VAL taking priority over the load enable.
module pipe_reg #(
   parameter int           W       = 32,
   parameter logic [W-1:0] RST_VAL = '0,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Clear beats enable so a flush always inserts a bubble, even while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_q <= RST_VAL;
      else if (i_clr)
         r_q <= CLR_VAL;
      else if (i_en)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the 5-stage RV32I core with
// hazard-control application, per-stage valid bits and stall/flush counters.
module pipe_stage_regs
   import pipe_stage_regs_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                StallF,
   input  logic                StallD,
   input  logic                FlushD,
   input  logic                FlushE,
   input  logic [XLEN-1:0]     PCNextF,
   input  logic [31:0]         InstrF,
   output logic [XLEN-1:0]     PCF,
   output logic [31:0]         InstrD,
   output logic [XLEN-1:0]     PCD,
   output logic                ValidD,
   input  logic [CTRL_W-1:0]   CtrlD,
   input  logic [3*XLEN-1:0]   OpsD,
   input  logic [REGS_W-1:0]   RegsD,
   output logic [CTRL_W-1:0]   CtrlE,
   output logic [3*XLEN-1:0]   OpsE,
   output logic [REGS_W-1:0]   RegsE,
   output logic [XLEN-1:0]     PCE,
   output logic                ValidE,
   output logic [CNT_W-1:0]    StallCnt,
   output logic [CNT_W-1:0]    FlushCnt
);

   localparam int IFID_W = 32 + XLEN + 1;
   localparam int IDEX_W = CTRL_W + 3*XLEN + REGS_W + XLEN + 1;

   // IF/ID bubble: NOP, PC 0, invalid. Also its reset value.
   localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {XLEN{1'b0}}, 1'b0};

   logic [IFID_W-1:0] w_ifid_d, w_ifid_q;
   logic [IDEX_W-1:0] w_idex_d, w_idex_q;
   logic              w_stall_evt;
   logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

   // Fetch PC: hold on StallF, never cleared
   pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC), .CLR_VAL('0)) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (~StallF),
      .i_clr (1'b0),
      .i_d   (PCNextF),
      .o_q   (PCF)
   );

   assign w_ifid_d = {InstrF, PCF, 1'b1};

   // IF/ID: FlushD > StallD > load
   pipe_reg #(.W(IFID_W), .RST_VAL(IFID_BUBBLE), .CLR_VAL(IFID_BUBBLE)) u_ifid (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (~StallD),
      .i_clr (FlushD),
      .i_d   (w_ifid_d),
      .o_q   (w_ifid_q)
   );

   assign {InstrD, PCD, ValidD} = w_ifid_q;

   // An all-zero ID/EX is a harmless bubble: no writes, no branches, RdE=0
   assign w_idex_d = {CtrlD, OpsD, RegsD, PCD, ValidD};

   pipe_reg #(.W(IDEX_W), .RST_VAL('0), .CLR_VAL('0)) u_idex (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (1'b1),
      .i_clr (FlushE),
      .i_d   (w_idex_d),
      .o_q   (w_idex_q)
   );

   assign {CtrlE, OpsE, RegsE, PCE, ValidE} = w_idex_q;

   // A stall only counts when it actually holds IF/ID (a flush overrides it)
   assign w_stall_evt = StallD & ~FlushD;

   // Saturating performance counters for effective D-stalls and E-flushes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (FlushE && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign StallCnt = r_stall_cnt;
   assign FlushCnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, straight-line flow, load-use,
// taken branch, flush-over-stall, counter saturation and async reset.
module tb_pipe_stage_regs;
   import pipe_stage_regs_pkg::*;

   localparam int              XLEN     = 32;
   localparam int              CNT_W    = 4;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_1000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              StallF, StallD, FlushD, FlushE;
   logic [XLEN-1:0]   PCNextF;
   logic [31:0]       InstrF;
   logic [XLEN-1:0]   PCF, PCD, PCE;
   logic [31:0]       InstrD;
   logic              ValidD, ValidE;
   logic [CTRL_W-1:0] CtrlD, CtrlE;
   logic [3*XLEN-1:0] OpsD, OpsE;
   logic [REGS_W-1:0] RegsD, RegsE;
   logic [CNT_W-1:0]  StallCnt, FlushCnt;

   int n_cmp = 0;
   int n_err = 0;

   // addi x1,x0,10 : RegWrite, ALU result, ALUSrc=imm
   localparam logic [31:0]       I_A   = 32'h00A0_0093;
   localparam logic [CTRL_W-1:0] C_A   = {1'b1, RS_ALU, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
   localparam logic [3*XLEN-1:0] OPS_A = {32'h0000_0000, 32'h0000_0000, 32'h0000_000A};
   localparam logic [REGS_W-1:0] R_A   = 15'h0001;
   // lw x4,0(x2) style bundle
   localparam logic [31:0]       I_B   = 32'h0001_2203;
   localparam logic [CTRL_W-1:0] C_B   = {1'b1, RS_LOAD, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
   localparam logic [3*XLEN-1:0] OPS_B = {32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0004};
   localparam logic [REGS_W-1:0] R_B   = 15'h0864;
   localparam logic [31:0]       I_C   = 32'h0020_8133;
   localparam logic [31:0]       I_D   = 32'h0031_01B3;

   pipe_stage_regs #(.XLEN(XLEN), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .StallF   (StallF),
      .StallD   (StallD),
      .FlushD   (FlushD),
      .FlushE   (FlushE),
      .PCNextF  (PCNextF),
      .InstrF   (InstrF),
      .PCF      (PCF),
      .InstrD   (InstrD),
      .PCD      (PCD),
      .ValidD   (ValidD),
      .CtrlD    (CtrlD),
      .OpsD     (OpsD),
      .RegsD    (RegsD),
      .CtrlE    (CtrlE),
      .OpsE     (OpsE),
      .RegsE    (RegsE),
      .PCE      (PCE),
      .ValidE   (ValidE),
      .StallCnt (StallCnt),
      .FlushCnt (FlushCnt)
   );

   always #5 clk = ~clk;

   // One clock edge, then settle 1 ns before sampling / driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctl();
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         StallF  = 1'($urandom); StallD = 1'($urandom);
         FlushD  = 1'($urandom); FlushE = 1'($urandom);
         PCNextF = $urandom;     InstrF = $urandom;
         CtrlD   = 10'($urandom); OpsD  = {$urandom, $urandom, $urandom};
         RegsD   = 15'($urandom);
         step();
      end
      n_cmp++; if (PCF !== RESET_PC) begin n_err++; $display("FAIL rst_pcf got %h want %h", PCF, RESET_PC); end
      n_cmp++; if (InstrD !== 32'h13) begin n_err++; $display("FAIL rst_instrd got %h want %h", InstrD, 32'h13); end
      n_cmp++; if (ValidD !== 1'b0 || ValidE !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b%b want 00", ValidD, ValidE); end
      n_cmp++; if (StallCnt !== 4'd0 || FlushCnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", StallCnt, FlushCnt); end
      n_cmp++; if (CtrlE !== '0 || RegsE !== '0 || OpsE !== '0 || PCE !== '0 || PCD !== '0) begin n_err++; $display("FAIL rst_regs got ctrl=%h regs=%h pce=%h pcd=%h want zeros", CtrlE, RegsE, PCE, PCD); end
      $display("txn reset: PCF=%h InstrD=%h", PCF, InstrD);
   endtask

   task automatic test_straight_line();
      idle_ctl();
      PCNextF = RESET_PC + 32'd4; InstrF = I_A;
      CtrlD = 10'h3FF; OpsD = '1; RegsD = 15'h7FFF;
      rst_n = 1'b1;
      step();
      $display("txn straight1: PCF=%h InstrD=%h PCD=%h", PCF, InstrD, PCD);
      n_cmp++; if (PCF !== 32'h1004) begin n_err++; $display("FAIL sl_pcf1 got %h want %h", PCF, 32'h1004); end
      n_cmp++; if (InstrD !== I_A || PCD !== 32'h1000 || ValidD !== 1'b1) begin n_err++; $display("FAIL sl_d1 got %h/%h/%b want %h/%h/1", InstrD, PCD, ValidD, I_A, 32'h1000); end
      n_cmp++; if (ValidE !== 1'b0) begin n_err++; $display("FAIL sl_ve1 got %b want 0", ValidE); end
      PCNextF = 32'h1008; InstrF = I_B;
      CtrlD = C_A; OpsD = OPS_A; RegsD = R_A;
      step();
      $display("txn straight2: CtrlE=%h RegsE=%h PCE=%h ValidE=%b", CtrlE, RegsE, PCE, ValidE);
      n_cmp++; if (CtrlE !== C_A || RegsE !== R_A || OpsE !== OPS_A) begin n_err++; $display("FAIL sl_e2 got %h/%h want %h/%h", CtrlE, RegsE, C_A, R_A); end
      n_cmp++; if (PCE !== 32'h1000 || ValidE !== 1'b1) begin n_err++; $display("FAIL sl_pce2 got %h/%b want %h/1", PCE, ValidE, 32'h1000); end
      n_cmp++; if (PCF !== 32'h1008 || InstrD !== I_B || PCD !== 32'h1004) begin n_err++; $display("FAIL sl_fd2 got %h/%h/%h want %h/%h/%h", PCF, InstrD, PCD, 32'h1008, I_B, 32'h1004); end
   endtask

   task automatic test_load_use();
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1; FlushD = 1'b0;
      PCNextF = 32'h2000; InstrF = 32'hFFFF_FFFF;
      CtrlD = C_B; OpsD = OPS_B; RegsD = R_B;
      step();
      $display("txn load_use: PCF=%h InstrD=%h ValidE=%b Cnt=%0d/%0d", PCF, InstrD, ValidE, StallCnt, FlushCnt);
      n_cmp++; if (PCF !== 32'h1008) begin n_err++; $display("FAIL lu_pcf got %h want %h", PCF, 32'h1008); end
      n_cmp++; if (InstrD !== I_B || PCD !== 32'h1004 || ValidD !== 1'b1) begin n_err++; $display("FAIL lu_d got %h/%h/%b want %h/%h/1", InstrD, PCD, ValidD, I_B, 32'h1004); end
      n_cmp++; if (ValidE !== 1'b0 || RegsE !== '0 || CtrlE !== '0 || OpsE !== '0) begin n_err++; $display("FAIL lu_e got v=%b regs=%h ctrl=%h want 0/0/0", ValidE, RegsE, CtrlE); end
      n_cmp++; if (StallCnt !== 4'd1 || FlushCnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt got %0d/%0d want 1/1", StallCnt, FlushCnt); end
      // instruction re-issues into E the next cycle
      idle_ctl();
      PCNextF = 32'h100C; InstrF = I_C;
      step();
      $display("txn reissue: CtrlE=%h PCE=%h ValidE=%b", CtrlE, PCE, ValidE);
      n_cmp++; if (CtrlE !== C_B || RegsE !== R_B || PCE !== 32'h1004 || ValidE !== 1'b1) begin n_err++; $display("FAIL lu_reissue got %h/%h/%h/%b want %h/%h/%h/1", CtrlE, RegsE, PCE, ValidE, C_B, R_B, 32'h1004); end
      n_cmp++; if (PCF !== 32'h100C || InstrD !== I_C) begin n_err++; $display("FAIL lu_next got %h/%h want %h/%h", PCF, InstrD, 32'h100C, I_C); end
   endtask

   task automatic test_branch();
      FlushD = 1'b1; FlushE = 1'b1; StallF = 1'b0; StallD = 1'b0;
      PCNextF = 32'h0000_0100; InstrF = I_D;
      step();
      $display("txn branch: PCF=%h InstrD=%h ValidD=%b CtrlE=%h", PCF, InstrD, ValidD, CtrlE);
      n_cmp++; if (PCF !== 32'h100) begin n_err++; $display("FAIL br_pcf got %h want %h", PCF, 32'h100); end
      n_cmp++; if (InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== '0) begin n_err++; $display("FAIL br_d got %h/%b/%h want 13/0/0", InstrD, ValidD, PCD); end
      n_cmp++; if (CtrlE !== '0 || ValidE !== 1'b0 || PCE !== '0) begin n_err++; $display("FAIL br_e got %h/%b/%h want 0/0/0", CtrlE, ValidE, PCE); end
      n_cmp++; if (StallCnt !== 4'd1 || FlushCnt !== 4'd2) begin n_err++; $display("FAIL br_cnt got %0d/%0d want 1/2", StallCnt, FlushCnt); end
      idle_ctl();
      PCNextF = 32'h104; InstrF = I_D;
      step();
      $display("txn branch_target: InstrD=%h PCD=%h ValidD=%b ValidE=%b", InstrD, PCD, ValidD, ValidE);
      n_cmp++; if (InstrD !== I_D || PCD !== 32'h100 || ValidD !== 1'b1 || ValidE !== 1'b0) begin n_err++; $display("FAIL br_tgt got %h/%h/%b/%b want %h/100/1/0", InstrD, PCD, ValidD, ValidE, I_D); end
   endtask

   task automatic test_flush_over_stall();
      StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; FlushE = 1'b0;
      PCNextF = 32'h3000; InstrF = I_A;
      step();
      $display("txn flush_stall: InstrD=%h ValidD=%b StallCnt=%0d", InstrD, ValidD, StallCnt);
      n_cmp++; if (InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== '0) begin n_err++; $display("FAIL fs_d got %h/%b/%h want 13/0/0", InstrD, ValidD, PCD); end
      n_cmp++; if (StallCnt !== 4'd1 || FlushCnt !== 4'd2) begin n_err++; $display("FAIL fs_cnt got %0d/%0d want 1/2", StallCnt, FlushCnt); end
      n_cmp++; if (PCF !== 32'h104) begin n_err++; $display("FAIL fs_pcf got %h want %h", PCF, 32'h104); end
      n_cmp++; if (ValidE !== 1'b1 || PCE !== 32'h100) begin n_err++; $display("FAIL fs_e got %b/%h want 1/100", ValidE, PCE); end
   endtask

   task automatic test_saturation();
      // refill D with a real instruction, then hold it for 20 cycles
      idle_ctl();
      PCNextF = 32'h108; InstrF = I_C;
      step();
      StallF = 1'b1; StallD = 1'b1;
      for (int i = 0; i < 20; i++) step();
      $display("txn saturate: StallCnt=%0d InstrD=%h", StallCnt, InstrD);
      n_cmp++; if (StallCnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt got %0d want 15", StallCnt); end
      n_cmp++; if (InstrD !== I_C || PCD !== 32'h104 || PCF !== 32'h108) begin n_err++; $display("FAIL sat_hold got %h/%h/%h want %h/104/108", InstrD, PCD, PCF, I_C); end
      n_cmp++; if (FlushCnt !== 4'd2) begin n_err++; $display("FAIL sat_fcnt got %0d want 2", FlushCnt); end
      // asynchronous reset between edges clears everything at once
      #3 rst_n = 1'b0;
      #1;
      $display("txn async_reset: StallCnt=%0d PCF=%h ValidD=%b", StallCnt, PCF, ValidD);
      n_cmp++; if (StallCnt !== 4'd0 || FlushCnt !== 4'd0) begin n_err++; $display("FAIL ar_cnt got %0d/%0d want 0/0", StallCnt, FlushCnt); end
      n_cmp++; if (PCF !== RESET_PC || InstrD !== 32'h13 || ValidD !== 1'b0 || ValidE !== 1'b0) begin n_err++; $display("FAIL ar_state got %h/%h/%b/%b want %h/13/0/0", PCF, InstrD, ValidD, ValidE, RESET_PC); end
      // first edge after release loads normally
      idle_ctl();
      PCNextF = 32'h1004; InstrF = I_D;
      #2 rst_n = 1'b1;
      step();
      $display("txn post_reset: PCF=%h InstrD=%h PCD=%h ValidD=%b", PCF, InstrD, PCD, ValidD);
      n_cmp++; if (PCF !== 32'h1004 || InstrD !== I_D || PCD !== 32'h1000 || ValidD !== 1'b1) begin n_err++; $display("FAIL pr_load got %h/%h/%h/%b want 1004/%h/1000/1", PCF, InstrD, PCD, ValidD, I_D); end
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_load_use();
      test_branch();
      test_flush_over_stall();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
